// File: rtl/adc_scan_ctrl.sv
// adc_scan_ctrl: round-robin scan controller for an ADC0808-style 8-input converter.
// Walks the enabled channels in ch_mask, sequences ADD A/B/C, ALE, START and OE with
// configurable widths, guards EOC with a timeout and hands each result, tagged with its
// channel, to downstream logic over a valid/ready stream.
//
// Ports:
//   clk, reset        system clock, asynchronous active-high reset
//   enable            level-sensitive scan run request
//   ch_mask           per-channel enable, bit i enables channel i
//   eoc, adc_data     converter end-of-conversion and parallel data
//   adc_addr          ADD C/B/A channel select
//   ale, start, oe    converter control strobes
//   sample_valid      result available (held until sample_ready)
//   sample_data/ch    captured conversion and its channel
//   sample_ready      downstream accepts the result
//   timeout_err       one-cycle pulse when EOC never arrives
//   busy              high whenever the scanner is not idle
module adc_scan_ctrl #(
  parameter int unsigned NUM_CH    = 8,
  parameter int unsigned PULSE_CYC = 4,
  parameter int unsigned EOC_WAIT  = 8,
  parameter int unsigned OE_CYC    = 2,
  parameter int unsigned TIMEOUT   = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic              eoc,
  input  logic [7:0]        adc_data,
  output logic [2:0]        adc_addr,
  output logic              ale,
  output logic              start,
  output logic              oe,
  output logic              sample_valid,
  output logic [7:0]        sample_data,
  output logic [2:0]        sample_ch,
  input  logic              sample_ready,
  output logic              timeout_err,
  output logic              busy
);

  // One shared counter, wide enough for the largest phase length.
  localparam int unsigned Max1   = (PULSE_CYC > EOC_WAIT) ? PULSE_CYC : EOC_WAIT;
  localparam int unsigned Max2   = (Max1 > OE_CYC) ? Max1 : OE_CYC;
  localparam int unsigned CntMax = (Max2 > TIMEOUT) ? Max2 : TIMEOUT;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] CntOne      = CntW'(1);
  localparam logic [CntW-1:0] PulseLast   = CntW'(PULSE_CYC - 1);
  localparam logic [CntW-1:0] BlankLast   = CntW'(EOC_WAIT - 1);
  localparam logic [CntW-1:0] OeLast      = CntW'(OE_CYC - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StPulse,
    StBlank,
    StWaitEoc,
    StRead,
    StPush,
    StNext
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      cur_ch_q;

  logic [2:0] first_ch;
  logic [2:0] next_ch;
  logic       mask_any;

  assign mask_any = |ch_mask;

  // first_ch: lowest enabled channel. next_ch: lowest enabled channel strictly above
  // cur_ch_q, falling back to first_ch when none is above (wrap-around).
  always_comb begin
    first_ch = 3'd0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (ch_mask[i]) first_ch = 3'(i);
    end
    next_ch = first_ch;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (ch_mask[i] && (3'(i) > cur_ch_q)) next_ch = 3'(i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      cur_ch_q     <= '0;
      adc_addr     <= '0;
      ale          <= 1'b0;
      start        <= 1'b0;
      oe           <= 1'b0;
      sample_valid <= 1'b0;
      sample_data  <= '0;
      sample_ch    <= '0;
      timeout_err  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state_q)
        StIdle: begin
          if (enable && mask_any) begin
            cur_ch_q <= first_ch;
            adc_addr <= first_ch;
            busy     <= 1'b1;
            state_q  <= StSetup;
          end
        end
        StSetup: begin
          cnt_q   <= '0;
          ale     <= 1'b1;
          start   <= 1'b1;
          state_q <= StPulse;
        end
        StPulse: begin
          if (cnt_q == PulseLast) begin
            ale     <= 1'b0;
            start   <= 1'b0;
            cnt_q   <= '0;
            state_q <= StBlank;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        StBlank: begin
          if (cnt_q == BlankLast) begin
            cnt_q   <= '0;
            state_q <= StWaitEoc;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        StWaitEoc: begin
          if (eoc) begin
            cnt_q   <= '0;
            oe      <= 1'b1;
            state_q <= StRead;
          end else if (cnt_q == TimeoutLast) begin
            timeout_err <= 1'b1;
            state_q     <= StNext;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        StRead: begin
          if (cnt_q == OeLast) begin
            oe           <= 1'b0;
            sample_data  <= adc_data;
            sample_ch    <= cur_ch_q;
            sample_valid <= 1'b1;
            state_q      <= StPush;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        StPush: begin
          // Stall here under backpressure; the scan resumes only after the transfer.
          if (sample_ready) begin
            sample_valid <= 1'b0;
            state_q      <= StNext;
          end
        end
        StNext: begin
          if (!enable || !mask_any) begin
            busy    <= 1'b0;
            state_q <= StIdle;
          end else begin
            cur_ch_q <= next_ch;
            adc_addr <= next_ch;
            state_q  <= StSetup;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Bench for adc_scan_ctrl: randomized masks, data and EOC delays against a behavioural
// model (channel list built from the mask, ADC model supplying data and EOC timing).
module tb_adc_scan_ctrl;

  localparam int unsigned NumCh    = 8;
  localparam int unsigned PulseCyc = 4;
  localparam int unsigned EocWait  = 8;
  localparam int unsigned OeCyc    = 2;
  localparam int unsigned Timeout  = 32;
  localparam int          Latency  = 1 + PulseCyc + EocWait + 1 + OeCyc;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic [NumCh-1:0] ch_mask;
  logic             eoc;
  logic [7:0]       adc_data;
  logic [2:0]       adc_addr;
  logic             ale;
  logic             start;
  logic             oe;
  logic             sample_valid;
  logic [7:0]       sample_data;
  logic [2:0]       sample_ch;
  logic             sample_ready;
  logic             timeout_err;
  logic             busy;

  adc_scan_ctrl #(
    .NUM_CH   (NumCh),
    .PULSE_CYC(PulseCyc),
    .EOC_WAIT (EocWait),
    .OE_CYC   (OeCyc),
    .TIMEOUT  (Timeout)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .ch_mask     (ch_mask),
    .eoc         (eoc),
    .adc_data    (adc_data),
    .adc_addr    (adc_addr),
    .ale         (ale),
    .start       (start),
    .oe          (oe),
    .sample_valid(sample_valid),
    .sample_data (sample_data),
    .sample_ch   (sample_ch),
    .sample_ready(sample_ready),
    .timeout_err (timeout_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // ADC model state
  int         eoc_delay;
  bit         armed;
  int         since_fall;
  logic [7:0] conv_data;

  // Monitor state
  typedef struct packed {
    logic [2:0] ch;
    logic [7:0] data;
    logic [7:0] exp_data;
  } xfer_t;

  int         cyc;
  int         fall_cyc;
  int         busy_rise;
  bit         lat_pend;
  bit         start_prev, oe_prev, to_prev, busy_prev, valid_prev;
  int         ale_run, start_run, oe_run, valid_run, to_run;
  int         ale_len_q[$], start_len_q[$], oe_len_q[$], valid_len_q[$], to_len_q[$];
  int         to_delta_q[$], lat_q[$];
  logic [2:0] addr_q[$], oeaddr_q[$];
  xfer_t      xfer_q[$];
  logic [2:0] chs[$];

  task automatic clear_mon();
    cyc = 0; fall_cyc = -1000; busy_rise = 0; lat_pend = 1'b0;
    start_prev = 1'b0; oe_prev = 1'b0; to_prev = 1'b0; busy_prev = 1'b0; valid_prev = 1'b0;
    ale_run = 0; start_run = 0; oe_run = 0; valid_run = 0; to_run = 0;
    ale_len_q.delete(); start_len_q.delete(); oe_len_q.delete(); valid_len_q.delete();
    to_len_q.delete(); to_delta_q.delete(); lat_q.delete(); addr_q.delete(); oeaddr_q.delete();
    xfer_q.delete();
    armed = 1'b0; since_fall = 0; eoc = 1'b0;
  endtask

  // Reference channel order: enabled channels ascending, visited cyclically.
  task automatic set_model(input logic [NumCh-1:0] mask);
    chs.delete();
    for (int i = 0; i < int'(NumCh); i++) if (mask[i]) chs.push_back(3'(i));
  endtask

  // Advance one cycle. The transfer is logged before the edge, with inputs already final.
  task automatic tick();
    xfer_t x;
    if (sample_valid === 1'b1 && sample_ready === 1'b1) begin
      x.ch = sample_ch; x.data = sample_data; x.exp_data = conv_data;
      xfer_q.push_back(x);
    end
    @(negedge clk);
    cyc++;
    if (start && !start_prev) begin
      addr_q.push_back(adc_addr);
      conv_data = 8'($urandom);
      adc_data  = conv_data;
      armed     = 1'b0;
      eoc       = 1'b0;
    end
    if (!start && start_prev) begin
      armed = 1'b1; since_fall = 0; fall_cyc = cyc;
    end else if (armed) begin
      since_fall++;
    end
    if (armed && eoc_delay >= 0 && since_fall >= eoc_delay) eoc = 1'b1;
    if (oe && !oe_prev) oeaddr_q.push_back(adc_addr);
    if (timeout_err && !to_prev) to_delta_q.push_back(cyc - fall_cyc);
    if (busy && !busy_prev) begin busy_rise = cyc; lat_pend = 1'b1; end
    if (sample_valid && !valid_prev && lat_pend) begin
      lat_q.push_back(cyc - busy_rise); lat_pend = 1'b0;
    end
    if (ale) ale_run++; else if (ale_run > 0) begin ale_len_q.push_back(ale_run); ale_run = 0; end
    if (start) start_run++;
    else if (start_run > 0) begin start_len_q.push_back(start_run); start_run = 0; end
    if (oe) oe_run++; else if (oe_run > 0) begin oe_len_q.push_back(oe_run); oe_run = 0; end
    if (sample_valid) valid_run++;
    else if (valid_run > 0) begin valid_len_q.push_back(valid_run); valid_run = 0; end
    if (timeout_err) to_run++; else if (to_run > 0) begin to_len_q.push_back(to_run); to_run = 0; end
    start_prev = start; oe_prev = oe; to_prev = timeout_err; busy_prev = busy;
    valid_prev = sample_valid;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; ch_mask = '0; sample_ready = 1'b0;
    adc_data = '0; eoc_delay = -1; eoc = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    clear_mon();
  endtask

  task automatic run_until_xfers(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (xfer_q.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; ch_mask = '0; sample_ready = 1'b0; eoc = 1'b0; adc_data = '0;
    #1;
    vectors++;
    if ({adc_addr, ale, start, oe, sample_valid, sample_data, sample_ch, timeout_err, busy}
        !== 20'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, required 0",
               {adc_addr, ale, start, oe, sample_valid, sample_data, sample_ch, timeout_err, busy});
    end
    do_reset();
    enable = 1'b1;  // empty mask: must stay idle
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if ({adc_addr, ale, start, oe, sample_valid, sample_data, sample_ch, timeout_err, busy}
          !== 20'h0) begin
        errors++;
        $display("FAIL idle_after_reset: cycle %0d got %h, required 0", i,
                 {adc_addr, ale, start, oe, sample_valid, sample_data, sample_ch, timeout_err, busy});
      end
    end
  endtask

  task automatic test_single_channel();
    bit ok;
    do_reset();
    ch_mask = 8'h01; set_model(ch_mask);
    eoc_delay = 20; sample_ready = 1'b1; enable = 1'b1;
    run_until_xfers(3, 400, ok);
    repeat (3) tick();
    vectors++;
    if (!ok) begin
      errors++; $display("FAIL single_progress: %0d transfers, required 3", xfer_q.size());
    end
    for (int k = 0; k < 3 && k < xfer_q.size(); k++) begin
      vectors++;
      if (xfer_q[k].ch !== 3'd0 || xfer_q[k].data !== xfer_q[k].exp_data) begin
        errors++;
        $display("FAIL single_sample%0d: ch %0d data %h, required ch 0 data %h", k,
                 xfer_q[k].ch, xfer_q[k].data, xfer_q[k].exp_data);
      end
    end
    for (int k = 0; k < 3 && k < ale_len_q.size() && k < start_len_q.size()
         && k < oe_len_q.size() && k < valid_len_q.size() && k < addr_q.size()
         && k < oeaddr_q.size(); k++) begin
      vectors++;
      if (ale_len_q[k] != int'(PulseCyc) || start_len_q[k] != int'(PulseCyc) ||
          oe_len_q[k] != int'(OeCyc) || valid_len_q[k] != 1 ||
          addr_q[k] !== 3'd0 || oeaddr_q[k] !== 3'd0) begin
        errors++;
        $display("FAIL single_strobes%0d: ale %0d start %0d oe %0d valid %0d addr %0d/%0d, %s",
                 k, ale_len_q[k], start_len_q[k], oe_len_q[k], valid_len_q[k], addr_q[k],
                 oeaddr_q[k], "required 4 4 2 1 addr 0/0");
      end
    end
  endtask

  task automatic test_mask_sequence(input logic [NumCh-1:0] mask, input int n);
    bit ok;
    int lat;
    int m;
    do_reset();
    ch_mask = mask; set_model(mask);
    eoc_delay = 0; sample_ready = 1'b1; enable = 1'b1;
    run_until_xfers(n, n * 40, ok);
    m = chs.size();
    vectors++;
    if (!ok) begin
      errors++;
      $display("FAIL seq_progress mask %h: %0d transfers, required %0d", mask, xfer_q.size(), n);
    end
    lat = (lat_q.size() > 0) ? lat_q[0] : -1;
    vectors++;
    if (lat != Latency) begin
      errors++; $display("FAIL seq_latency mask %h: %0d cycles, required %0d", mask, lat, Latency);
    end
    for (int k = 0; k < n && k < xfer_q.size() && k < addr_q.size(); k++) begin
      vectors++;
      if (xfer_q[k].ch !== chs[k % m] || addr_q[k] !== chs[k % m] ||
          xfer_q[k].data !== xfer_q[k].exp_data) begin
        errors++;
        $display("FAIL seq_sample%0d mask %h: ch %0d addr %0d data %h, required ch %0d data %h",
                 k, mask, xfer_q[k].ch, addr_q[k], xfer_q[k].data, chs[k % m],
                 xfer_q[k].exp_data);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    bit seen;
    int m;
    do_reset();
    ch_mask = 8'($urandom_range(1, 255)); set_model(ch_mask);
    m = chs.size();
    eoc_delay = int'($urandom_range(0, 12)); sample_ready = 1'b0; enable = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (sample_valid === 1'b1) begin seen = 1'b1; break; end
    end
    vectors++;
    if (!seen) begin errors++; $display("FAIL bp_valid: no sample_valid, required one"); end
    for (int i = 0; i < 50; i++) begin
      vectors++;
      if ({sample_valid, ale, start, oe, sample_ch, sample_data} !==
          {1'b1, 1'b0, 1'b0, 1'b0, chs[0], conv_data}) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: v/ale/start/oe/ch/data %b%b%b%b %0d %h, required 1000 %0d %h",
                 i, sample_valid, ale, start, oe, sample_ch, sample_data, chs[0], conv_data);
      end
      tick();
    end
    sample_ready = 1'b1;
    tick();
    vectors++;
    if (xfer_q.size() != 1 || xfer_q[0].ch !== chs[0] || xfer_q[0].data !== xfer_q[0].exp_data) begin
      errors++;
      $display("FAIL bp_transfer: %0d transfers, required exactly 1 on ch %0d", xfer_q.size(), chs[0]);
    end
    vectors++;
    if (sample_valid !== 1'b0) begin
      errors++; $display("FAIL bp_valid_drop: sample_valid %b, required 0", sample_valid);
    end
    run_until_xfers(3, 200, ok);
    for (int k = 1; k < 3 && k < xfer_q.size(); k++) begin
      vectors++;
      if (xfer_q[k].ch !== chs[k % m] || xfer_q[k].data !== xfer_q[k].exp_data) begin
        errors++;
        $display("FAIL bp_resume%0d: ch %0d data %h, required ch %0d data %h", k, xfer_q[k].ch,
                 xfer_q[k].data, chs[k % m], xfer_q[k].exp_data);
      end
    end
  endtask

  task automatic test_timeout();
    int m;
    do_reset();
    ch_mask = 8'($urandom_range(1, 255)); set_model(ch_mask);
    m = chs.size();
    eoc_delay = -1; sample_ready = 1'b1; enable = 1'b1;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (to_len_q.size() >= 3) break;
    end
    vectors++;
    if (to_len_q.size() < 3) begin
      errors++; $display("FAIL to_count: %0d timeout pulses, required 3", to_len_q.size());
    end
    for (int k = 0; k < 3 && k < to_len_q.size() && k < to_delta_q.size() && k < addr_q.size();
         k++) begin
      vectors++;
      if (to_len_q[k] != 1 || to_delta_q[k] != int'(EocWait + Timeout) || addr_q[k] !== chs[k % m])
      begin
        errors++;
        $display("FAIL to_pulse%0d: width %0d delay %0d addr %0d, required 1 %0d %0d", k,
                 to_len_q[k], to_delta_q[k], addr_q[k], EocWait + Timeout, chs[k % m]);
      end
    end
    vectors++;
    if (xfer_q.size() != 0 || valid_len_q.size() != 0 || sample_valid !== 1'b0) begin
      errors++;
      $display("FAIL to_no_sample: %0d transfers %0d valid pulses, required 0 0",
               xfer_q.size(), valid_len_q.size());
    end
  endtask

  task automatic test_enable_drop();
    bit seen;
    do_reset();
    ch_mask = 8'($urandom_range(1, 255)); set_model(ch_mask);
    eoc_delay = 20; sample_ready = 1'b1; enable = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (fall_cyc == cyc) begin seen = 1'b1; break; end
    end
    enable = 1'b0;
    vectors++;
    if (!seen) begin errors++; $display("FAIL drop_blank: START never fell, required a fall"); end
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (busy === 1'b0) begin seen = 1'b1; break; end
    end
    vectors++;
    if (!seen || xfer_q.size() != 1 || xfer_q[0].ch !== chs[0] ||
        xfer_q[0].data !== xfer_q[0].exp_data) begin
      errors++;
      $display("FAIL drop_complete: idle %0d transfers %0d, required idle 1 with 1 transfer on ch %0d",
               seen, xfer_q.size(), chs[0]);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++;
      if (busy !== 1'b0 || start !== 1'b0) begin
        errors++; $display("FAIL drop_idle cycle %0d: busy %b start %b, required 0 0", i, busy, start);
      end
    end
    ch_mask = '0; enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++;
      if (busy !== 1'b0 || ale !== 1'b0) begin
        errors++; $display("FAIL empty_mask cycle %0d: busy %b ale %b, required 0 0", i, busy, ale);
      end
    end
    vectors++;
    if (addr_q.size() != 1) begin
      errors++; $display("FAIL drop_no_restart: %0d conversions, required 1", addr_q.size());
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    do_reset();
    ch_mask = 8'($urandom_range(1, 255)); set_model(ch_mask);
    eoc_delay = int'($urandom_range(0, 15)); sample_ready = 1'b1; enable = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (oe === 1'b1) begin seen = 1'b1; break; end
    end
    vectors++;
    if (!seen) begin errors++; $display("FAIL rst_mid_oe: oe never rose, required 1"); end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({oe, ale, start, sample_valid, busy, timeout_err} !== 6'b0) begin
      errors++;
      $display("FAIL rst_mid_async: oe/ale/start/valid/busy/to %b, required 000000",
               {oe, ale, start, sample_valid, busy, timeout_err});
    end
    @(negedge clk);
    ch_mask = 8'($urandom_range(1, 255)); set_model(ch_mask);
    reset = 1'b0;
    clear_mon();
    run_until_xfers(2, 200, ok);
    vectors++;
    if (!ok || addr_q.size() < 1 || addr_q[0] !== chs[0] || xfer_q[0].ch !== chs[0] ||
        xfer_q[0].data !== xfer_q[0].exp_data) begin
      errors++;
      $display("FAIL rst_mid_restart: ok %0d first ch %0d, required ok 1 ch %0d", ok,
               (xfer_q.size() > 0) ? xfer_q[0].ch : 3'd0, chs[0]);
    end
    vectors++;
    if (xfer_q.size() < 2 || xfer_q[1].ch !== chs[1 % chs.size()]) begin
      errors++;
      $display("FAIL rst_mid_next: %0d transfers, required 2 with second on ch %0d",
               xfer_q.size(), chs[1 % chs.size()]);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_channel();
    test_mask_sequence(8'b1010_0100, 6);
    test_mask_sequence(8'($urandom_range(1, 255)), 5);
    test_mask_sequence(8'($urandom_range(1, 255)), 5);
    test_backpressure();
    test_timeout();
    test_enable_drop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
